// File: rtl/vx_mem_lane_serializer.sv
// Serializes a coalesced multi-lane memory request onto a single-lane port, lowest lane first,
// and returns each lane response as a onehot partial. Optional perf counters: VX_MEM_LANE_SER_PERF_EN.
module vx_mem_lane_serializer #(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned ADDR_WIDTH    = 26,
  parameter int unsigned FLAGS_WIDTH   = 1,
  parameter int unsigned DATA_SIZE     = 64,
  parameter int unsigned TAG_WIDTH     = 8,
  parameter int unsigned LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int unsigned OUT_TAG_WIDTH = TAG_WIDTH + LANE_W
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_req_valid,
  input  logic                               in_req_rw,
  input  logic [NUM_LANES-1:0]               in_req_mask,
  input  logic [NUM_LANES*DATA_SIZE-1:0]     in_req_byteen,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]    in_req_addr,
  input  logic [NUM_LANES*FLAGS_WIDTH-1:0]   in_req_flags,
  input  logic [NUM_LANES*DATA_SIZE*8-1:0]   in_req_data,
  input  logic [TAG_WIDTH-1:0]               in_req_tag,
  output logic                               in_req_ready,
  output logic                               in_rsp_valid,
  output logic [NUM_LANES-1:0]               in_rsp_mask,
  output logic [NUM_LANES*DATA_SIZE*8-1:0]   in_rsp_data,
  output logic [TAG_WIDTH-1:0]               in_rsp_tag,
  input  logic                               in_rsp_ready,
  output logic                               out_req_valid,
  output logic                               out_req_rw,
  output logic [DATA_SIZE-1:0]               out_req_byteen,
  output logic [ADDR_WIDTH-1:0]              out_req_addr,
  output logic [FLAGS_WIDTH-1:0]             out_req_flags,
  output logic [DATA_SIZE*8-1:0]             out_req_data,
  output logic [OUT_TAG_WIDTH-1:0]           out_req_tag,
  input  logic                               out_req_ready,
  input  logic                               out_rsp_valid,
  input  logic [DATA_SIZE*8-1:0]             out_rsp_data,
  input  logic [OUT_TAG_WIDTH-1:0]           out_rsp_tag,
  output logic                               out_rsp_ready
`ifdef VX_MEM_LANE_SER_PERF_EN
  ,
  output logic [31:0]                        perf_lane_reqs,
  output logic [31:0]                        perf_stall_cycles
`endif
);

  localparam int unsigned DW = DATA_SIZE * 8;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                                 state_q;
  logic [NUM_LANES-1:0]                   rem_q;
  logic                                   rw_q;
  logic [NUM_LANES-1:0][DATA_SIZE-1:0]    byteen_q;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]   addr_q;
  logic [NUM_LANES-1:0][FLAGS_WIDTH-1:0]  flags_q;
  logic [NUM_LANES-1:0][DW-1:0]           data_q;
  logic [TAG_WIDTH-1:0]                   tag_q;

  logic [LANE_W-1:0]    lane;
  logic [NUM_LANES-1:0] rem_next;
  logic                 last_lane;
  logic                 in_fire;
  logic                 out_fire;

  // Lowest pending lane wins.
  always_comb begin
    lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (rem_q[i]) lane = LANE_W'(i);
    end
  end

  assign rem_next  = rem_q & ~(NUM_LANES'(1) << lane);
  assign last_lane = (rem_next == '0);

  assign out_req_valid = reset & (state_q == StIssue);
  assign out_fire      = out_req_valid & out_req_ready;
  // Ready while issuing the last lane lets the next request land with no bubble.
  assign in_req_ready  = reset & ((state_q == StIdle) | (out_fire & last_lane));
  assign in_fire       = in_req_valid & in_req_ready;

  assign out_req_rw     = rw_q;
  assign out_req_byteen = byteen_q[lane];
  assign out_req_addr   = addr_q[lane];
  assign out_req_flags  = flags_q[lane];
  assign out_req_data   = data_q[lane];
  assign out_req_tag    = {tag_q, lane};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
    end else if (in_fire) begin
      rem_q   <= in_req_mask;
      state_q <= (in_req_mask != '0) ? StIssue : StIdle;
    end else if (out_fire) begin
      rem_q   <= rem_next;
      state_q <= last_lane ? StIdle : StIssue;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      rw_q     <= in_req_rw;
      byteen_q <= in_req_byteen;
      addr_q   <= in_req_addr;
      flags_q  <= in_req_flags;
      data_q   <= in_req_data;
      tag_q    <= in_req_tag;
    end
  end

  logic                 rsp_valid_q;
  logic [LANE_W-1:0]    rsp_lane_q;
  logic [DW-1:0]        rsp_data_q;
  logic [TAG_WIDTH-1:0] rsp_tag_q;
  logic                 out_rsp_fire;

  assign out_rsp_ready = reset & (~rsp_valid_q | in_rsp_ready);
  assign out_rsp_fire  = out_rsp_valid & out_rsp_ready;
  assign in_rsp_valid  = reset & rsp_valid_q;
  assign in_rsp_tag    = rsp_tag_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
    end else if (out_rsp_fire) begin
      rsp_valid_q <= 1'b1;
    end else if (in_rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (out_rsp_fire) begin
      rsp_lane_q <= out_rsp_tag[LANE_W-1:0];
      rsp_data_q <= out_rsp_data;
      rsp_tag_q  <= out_rsp_tag[OUT_TAG_WIDTH-1:LANE_W];
    end
  end

  // The wide partial response is expanded from the stored lane index.
  always_comb begin
    in_rsp_mask = '0;
    in_rsp_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rsp_lane_q == LANE_W'(i)) begin
        in_rsp_mask[i]         = 1'b1;
        in_rsp_data[i*DW +: DW] = rsp_data_q;
      end
    end
  end

`ifdef VX_MEM_LANE_SER_PERF_EN
  logic [31:0] perf_lane_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_lane_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (out_fire) perf_lane_q <= perf_lane_q + 32'd1;
      if (out_req_valid && !out_req_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_lane_reqs    = perf_lane_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && in_fire) begin
      assert (in_req_mask != '0) else $error("vx_mem_lane_serializer: empty request mask");
    end
  end
`endif

endmodule

// File: tb/tb_vx_mem_lane_serializer.sv
// Self-checking bench for vx_mem_lane_serializer: directed scenarios then random traffic, all
// checked each cycle against a queue-based model of lanes and partial responses.
module tb_vx_mem_lane_serializer;

  localparam int NL  = 4;
  localparam int AW  = 26;
  localparam int FW  = 1;
  localparam int DS  = 64;
  localparam int TW  = 8;
  localparam int LW  = 2;
  localparam int OTW = TW + LW;
  localparam int DW  = DS * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  in_req_valid, in_req_rw, in_req_ready;
  logic [NL-1:0]         in_req_mask;
  logic [NL*DS-1:0]      in_req_byteen;
  logic [NL*AW-1:0]      in_req_addr;
  logic [NL*FW-1:0]      in_req_flags;
  logic [NL*DW-1:0]      in_req_data;
  logic [TW-1:0]         in_req_tag;
  logic                  in_rsp_valid, in_rsp_ready;
  logic [NL-1:0]         in_rsp_mask;
  logic [NL*DW-1:0]      in_rsp_data;
  logic [TW-1:0]         in_rsp_tag;
  logic                  out_req_valid, out_req_rw, out_req_ready;
  logic [DS-1:0]         out_req_byteen;
  logic [AW-1:0]         out_req_addr;
  logic [FW-1:0]         out_req_flags;
  logic [DW-1:0]         out_req_data;
  logic [OTW-1:0]        out_req_tag;
  logic                  out_rsp_valid, out_rsp_ready;
  logic [DW-1:0]         out_rsp_data;
  logic [OTW-1:0]        out_rsp_tag;
`ifdef VX_MEM_LANE_SER_PERF_EN
  logic [31:0]           perf_lane_reqs, perf_stall_cycles;
`endif

  vx_mem_lane_serializer dut (
    .clk            (clk),
    .reset          (reset),
    .in_req_valid   (in_req_valid),
    .in_req_rw      (in_req_rw),
    .in_req_mask    (in_req_mask),
    .in_req_byteen  (in_req_byteen),
    .in_req_addr    (in_req_addr),
    .in_req_flags   (in_req_flags),
    .in_req_data    (in_req_data),
    .in_req_tag     (in_req_tag),
    .in_req_ready   (in_req_ready),
    .in_rsp_valid   (in_rsp_valid),
    .in_rsp_mask    (in_rsp_mask),
    .in_rsp_data    (in_rsp_data),
    .in_rsp_tag     (in_rsp_tag),
    .in_rsp_ready   (in_rsp_ready),
    .out_req_valid  (out_req_valid),
    .out_req_rw     (out_req_rw),
    .out_req_byteen (out_req_byteen),
    .out_req_addr   (out_req_addr),
    .out_req_flags  (out_req_flags),
    .out_req_data   (out_req_data),
    .out_req_tag    (out_req_tag),
    .out_req_ready  (out_req_ready),
    .out_rsp_valid  (out_rsp_valid),
    .out_rsp_data   (out_rsp_data),
    .out_rsp_tag    (out_rsp_tag),
    .out_rsp_ready  (out_rsp_ready)
`ifdef VX_MEM_LANE_SER_PERF_EN
    ,
    .perf_lane_reqs    (perf_lane_reqs),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  typedef struct {
    logic           rw;
    logic [DS-1:0]  be;
    logic [AW-1:0]  addr;
    logic [FW-1:0]  fl;
    logic [DW-1:0]  data;
    logic [OTW-1:0] tag;
  } lane_t;

  typedef struct {
    logic [LW-1:0]  lane;
    logic [DW-1:0]  data;
    logic [TW-1:0]  tag;
  } rsp_t;

  lane_t          pend[$];   // lanes still to be issued, in issue order
  rsp_t           rq[$];     // partial responses held by the output register (0 or 1)
  logic [OTW-1:0] pool[$];   // issued read tags awaiting a memory response

  int n_assert = 0;
  int n_fail   = 0;

  logic        e_in_ready, e_out_valid, e_rsp_valid, e_out_rsp_ready;
  logic        req_acc, rsp_acc;
  logic [31:0] e_lane_cnt, e_stall_cnt;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    if (!reset) begin
      e_in_ready = 0; e_out_valid = 0; e_rsp_valid = 0; e_out_rsp_ready = 0;
    end else begin
      e_out_valid     = pend.size() != 0;
      e_in_ready      = pend.size() == 0 || (pend.size() == 1 && out_req_ready);
      e_rsp_valid     = rq.size() != 0;
      e_out_rsp_ready = rq.size() == 0 || in_rsp_ready;
    end
    chk("in_req_ready", DW'(in_req_ready), DW'(e_in_ready));
    chk("out_req_valid", DW'(out_req_valid), DW'(e_out_valid));
    chk("in_rsp_valid", DW'(in_rsp_valid), DW'(e_rsp_valid));
    chk("out_rsp_ready", DW'(out_rsp_ready), DW'(e_out_rsp_ready));
    if (e_out_valid) begin
      chk("out_req_rw", DW'(out_req_rw), DW'(pend[0].rw));
      chk("out_req_byteen", DW'(out_req_byteen), DW'(pend[0].be));
      chk("out_req_addr", DW'(out_req_addr), DW'(pend[0].addr));
      chk("out_req_flags", DW'(out_req_flags), DW'(pend[0].fl));
      chk("out_req_data", out_req_data, pend[0].data);
      chk("out_req_tag", DW'(out_req_tag), DW'(pend[0].tag));
    end
    if (e_rsp_valid) begin
      chk("in_rsp_mask", DW'(in_rsp_mask), DW'(4'd1 << rq[0].lane));
      chk("in_rsp_tag", DW'(in_rsp_tag), DW'(rq[0].tag));
      for (int i = 0; i < NL; i++)
        chk($sformatf("in_rsp_data[%0d]", i), in_rsp_data[i*DW +: DW],
            (int'(rq[0].lane) == i) ? rq[0].data : '0);
    end
`ifdef VX_MEM_LANE_SER_PERF_EN
    chk("perf_lane_reqs", DW'(perf_lane_reqs), DW'(e_lane_cnt));
    chk("perf_stall_cycles", DW'(perf_stall_cycles), DW'(e_stall_cnt));
`endif
  endtask

  task automatic advance();
    lane_t l;
    rsp_t  r;
    @(posedge clk);
    req_acc = in_req_valid && e_in_ready;
    rsp_acc = out_rsp_valid && e_out_rsp_ready;
    if (!reset) begin
      pend.delete(); rq.delete(); pool.delete();
      e_lane_cnt = 0; e_stall_cnt = 0;
    end else begin
      if (e_out_valid && out_req_ready) begin
        if (!pend[0].rw) pool.push_back(pend[0].tag);
        void'(pend.pop_front());
        e_lane_cnt++;
      end else if (e_out_valid) begin
        e_stall_cnt++;
      end
      if (req_acc) begin
        for (int i = 0; i < NL; i++) begin
          if (in_req_mask[i]) begin
            l.rw   = in_req_rw;
            l.be   = in_req_byteen[i*DS +: DS];
            l.addr = in_req_addr[i*AW +: AW];
            l.fl   = in_req_flags[i*FW +: FW];
            l.data = in_req_data[i*DW +: DW];
            l.tag  = {in_req_tag, LW'(i)};
            pend.push_back(l);
          end
        end
      end
      if (e_rsp_valid && in_rsp_ready) void'(rq.pop_front());
      if (rsp_acc) begin
        r.lane = out_rsp_tag[LW-1:0];
        r.data = out_rsp_data;
        r.tag  = out_rsp_tag[OTW-1:LW];
        rq.push_back(r);
      end
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic rand_wide(output logic [DW-1:0] v);
    for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
  endtask

  task automatic drive_req(input logic rw, input logic [NL-1:0] mask, input logic [TW-1:0] tag);
    logic [DW-1:0] d;
    in_req_valid = 1'b1;
    in_req_rw    = rw;
    in_req_mask  = mask;
    in_req_tag   = tag;
    for (int i = 0; i < NL; i++) begin
      in_req_addr[i*AW +: AW]       = AW'($urandom);
      in_req_flags[i*FW +: FW]      = FW'($urandom);
      in_req_byteen[i*DS +: 32]     = $urandom;
      in_req_byteen[i*DS + 32 +: 32] = $urandom;
      rand_wide(d);
      in_req_data[i*DW +: DW] = d;
    end
  endtask

  task automatic drive_rsp(input logic [OTW-1:0] tag);
    logic [DW-1:0] d;
    rand_wide(d);
    out_rsp_valid = 1'b1;
    out_rsp_tag   = tag;
    out_rsp_data  = d;
  endtask

  initial begin
    int idx;
    reset = 0; in_req_valid = 0; in_req_rw = 0; in_req_mask = '0; in_req_byteen = '0;
    in_req_addr = '0; in_req_flags = '0; in_req_data = '0; in_req_tag = '0;
    in_rsp_ready = 0; out_req_ready = 0; out_rsp_valid = 0; out_rsp_data = '0;
    out_rsp_tag = '0; e_lane_cnt = 0; e_stall_cnt = 0; req_acc = 0; rsp_acc = 0;
    #1;
    cycle();
    sample();
    chk("reset_in_req_ready", DW'(in_req_ready), '0);
    chk("reset_out_req_valid", DW'(out_req_valid), '0);
    advance();
    reset = 1;

    // Read 1011: lanes 0,1,3 on consecutive cycles, ready pulses with lane 3.
    drive_req(1'b0, 4'b1011, 8'h5A); out_req_ready = 1;
    cycle();
    in_req_valid = 0;
    sample(); chk("t1_lane0_tag", DW'(out_req_tag), DW'(10'h168)); advance();
    sample(); chk("t1_lane1_tag", DW'(out_req_tag), DW'(10'h169)); advance();
    sample(); chk("t1_lane3_tag", DW'(out_req_tag), DW'(10'h16B));
    chk("t1_ready_pulse", DW'(in_req_ready), DW'(1'b1)); advance();
    sample(); chk("t1_idle", DW'(out_req_valid), '0); advance();

    // Same request with three stall cycles on lane 1.
    drive_req(1'b0, 4'b1011, 8'h5A);
    cycle();
    in_req_valid = 0;
    cycle();
    out_req_ready = 0;
    repeat (3) begin
      sample(); chk("t2_hold_tag", DW'(out_req_tag), DW'(10'h169)); advance();
    end
    out_req_ready = 1;
    sample(); chk("t2_release_tag", DW'(out_req_tag), DW'(10'h169)); advance();
    cycle();
`ifdef VX_MEM_LANE_SER_PERF_EN
    sample(); chk("t2_perf_stall", DW'(perf_stall_cycles), DW'(32'd3)); advance();
`endif

    // Back-to-back: lane 0 then lane 3 with no idle cycle between them.
    drive_req(1'b0, 4'b0001, 8'h11);
    cycle();
    drive_req(1'b0, 4'b1000, 8'h22);
    sample(); chk("t3_b2b_ready", DW'(in_req_ready), DW'(1'b1)); advance();
    in_req_valid = 0;
    sample(); chk("t3_lane3_valid", DW'(out_req_valid), DW'(1'b1));
    chk("t3_lane3_tag", DW'(out_req_tag), DW'(10'h08B)); advance();

    // Responses {5A,3} then {5A,0} with the coalescer always ready.
    in_rsp_ready = 1;
    drive_rsp(10'h16B);
    cycle();
    drive_rsp(10'h168);
    sample(); chk("t4_mask_lane3", DW'(in_rsp_mask), DW'(4'b1000));
    chk("t4_tag", DW'(in_rsp_tag), DW'(8'h5A)); advance();
    out_rsp_valid = 0;
    sample(); chk("t4_mask_lane0", DW'(in_rsp_mask), DW'(4'b0001)); advance();
    cycle();

    // Backpressure: second response must wait and not be lost.
    in_rsp_ready = 0;
    drive_rsp(10'h0C5);
    cycle();
    drive_rsp(10'h0C6);
    sample(); chk("t5_backpressure", DW'(out_rsp_ready), '0); advance();
    in_rsp_ready = 1;
    sample(); chk("t5_release", DW'(out_rsp_ready), DW'(1'b1)); advance();
    out_rsp_valid = 0;
    sample(); chk("t5_second_mask", DW'(in_rsp_mask), DW'(4'b0100)); advance();
    cycle();

    // Write 1111 with reset after the second lane.
    drive_req(1'b1, 4'b1111, 8'h33); out_req_ready = 1;
    cycle();
    in_req_valid = 0;
    cycle();
    cycle();
    reset = 0;
    cycle();
    reset = 1;
    sample(); chk("t6_no_valid", DW'(out_req_valid), '0);
    chk("t6_idle_ready", DW'(in_req_ready), DW'(1'b1));
    chk("t6_no_rsp", DW'(in_rsp_valid), '0); advance();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if (!in_req_valid || req_acc) begin
        if ($urandom_range(0, 2) != 0)
          drive_req(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 8'($urandom));
        else
          in_req_valid = 0;
      end
      if (!out_rsp_valid || rsp_acc) begin
        if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
          idx = $urandom_range(0, pool.size() - 1);
          drive_rsp(pool[idx]);
          pool.delete(idx);
        end else begin
          out_rsp_valid = 0;
        end
      end
      out_req_ready = $urandom_range(0, 3) != 0;
      in_rsp_ready  = $urandom_range(0, 3) != 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
